// File: rtl/jogador_pkg.sv
// Shared definitions for the automatic player.
// Holds the state encoding, which doubles as the db_estado debug code.
// Also holds the default timing/capacity values and two small helpers.
package jogador_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'h0,
        INICIA    = 4'h1,
        OUVE      = 4'h2,
        PRESSIONA = 4'h3,
        SOLTA     = 4'h4,
        FIM       = 4'hF
    } estado_t;

    localparam int JOGAR_CYCLES_DEF = 5;
    localparam int HOLD_CYCLES_DEF  = 10;
    localparam int GAP_CYCLES_DEF   = 10;
    localparam int QUIET_CYCLES_DEF = 100;
    localparam int MAX_SEQ_DEF      = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // A legal LED pattern has exactly one lamp lit.
    function automatic logic one_hot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/memoria_jogadas.sv
// Sequence memory for the automatic player: DEPTH x 4 bits.
// Ports: clock, we/waddr/wdata (synchronous write), raddr/rdata (combinational read).
// Contents are not reset; the controller never reads past the stored count.
module memoria_jogadas #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [3:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [3:0]    rdata
);

    logic [3:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/jogador_automatico.sv
// Automatic player for a memory (Genius-style) game.
// It starts a game, listens to the LED round and stores each new lamp.
// After a quiet period it replays the stored presses on the buttons, then listens again.
// Ports: clock, reset (async, active low), habilitar, leds[3:0], pronto ->
//        jogar, botoes[3:0], ocupado, erro_sequencia, db_estado[3:0].
module jogador_automatico
    import jogador_pkg::*;
#(
    parameter int JOGAR_CYCLES = JOGAR_CYCLES_DEF,
    parameter int HOLD_CYCLES  = HOLD_CYCLES_DEF,
    parameter int GAP_CYCLES   = GAP_CYCLES_DEF,
    parameter int QUIET_CYCLES = QUIET_CYCLES_DEF,
    parameter int MAX_SEQ      = MAX_SEQ_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilitar,
    input  logic [3:0] leds,
    input  logic       pronto,
    output logic       jogar,
    output logic [3:0] botoes,
    output logic       ocupado,
    output logic       erro_sequencia,
    output logic [3:0] db_estado
);

    localparam int DUR_MAX = max_int(JOGAR_CYCLES, max_int(HOLD_CYCLES, GAP_CYCLES));
    localparam int DW      = $clog2(DUR_MAX + 1);
    localparam int QW      = $clog2(QUIET_CYCLES + 1);
    localparam int NW      = $clog2(MAX_SEQ + 1);
    localparam int AW      = (MAX_SEQ > 1) ? $clog2(MAX_SEQ) : 1;

    localparam logic [DW-1:0] JOGAR_LAST = DW'(JOGAR_CYCLES - 1);
    localparam logic [DW-1:0] HOLD_LAST  = DW'(HOLD_CYCLES - 1);
    localparam logic [DW-1:0] GAP_LAST   = DW'(GAP_CYCLES - 1);
    localparam logic [QW-1:0] QUIET_T    = QW'(QUIET_CYCLES);
    localparam logic [NW-1:0] MAX_N      = NW'(MAX_SEQ);

    estado_t       st, nxt;
    logic [DW-1:0] dur_q, dur_d;
    logic [QW-1:0] quiet_q, quiet_d;
    logic [NW-1:0] n_q, n_d;
    logic [NW-1:0] idx_q, idx_d;
    logic          err_q, err_d;
    logic [3:0]    leds_r, leds_rr;
    logic          jogar_q;
    logic [3:0]    botoes_q;
    logic          we;
    logic [3:0]    rd_data;
    logic          rise;
    logic          busy;

    // A new entry is the registered LED value leaving zero.
    assign rise = (leds_r != 4'd0) && (leds_rr == 4'd0);
    assign busy = (st == INICIA) || (st == OUVE) || (st == PRESSIONA) || (st == SOLTA);

    // Read at the next index so botoes can be registered in step with the state.
    memoria_jogadas #(.DEPTH(MAX_SEQ), .AW(AW)) u_mem (
        .clock (clock),
        .we    (we),
        .waddr (n_q[AW-1:0]),
        .wdata (leds_r),
        .raddr (idx_d[AW-1:0]),
        .rdata (rd_data)
    );

    always_comb begin
        nxt     = st;
        dur_d   = dur_q;
        quiet_d = quiet_q;
        n_d     = n_q;
        idx_d   = idx_q;
        err_d   = err_q;
        we      = 1'b0;

        case (st)
            IDLE: if (habilitar) begin
                nxt   = INICIA;
                err_d = 1'b0;
                dur_d = '0;
            end
            INICIA: if (dur_q == JOGAR_LAST) begin
                nxt     = OUVE;
                dur_d   = '0;
                n_d     = '0;
                quiet_d = '0;
            end else begin
                dur_d = dur_q + 1'b1;
            end
            OUVE: begin
                if (rise) begin
                    quiet_d = '0;
                    if (n_q == MAX_N || !one_hot4(leds_r)) begin
                        err_d = 1'b1;
                        nxt   = FIM;
                    end else begin
                        we  = 1'b1;
                        n_d = n_q + 1'b1;
                    end
                end else if (leds_r != 4'd0) begin
                    quiet_d = '0;
                end else if (n_q != '0) begin
                    // Counting stops at the terminal value because the state leaves.
                    if (quiet_q == QUIET_T) begin
                        nxt   = PRESSIONA;
                        idx_d = '0;
                        dur_d = '0;
                    end else begin
                        quiet_d = quiet_q + 1'b1;
                    end
                end
            end
            PRESSIONA: if (dur_q == HOLD_LAST) begin
                nxt   = SOLTA;
                dur_d = '0;
            end else begin
                dur_d = dur_q + 1'b1;
            end
            SOLTA: if (dur_q == GAP_LAST) begin
                dur_d = '0;
                if (idx_q + 1'b1 == n_q) begin
                    nxt     = OUVE;
                    n_d     = '0;
                    quiet_d = '0;
                    idx_d   = '0;
                end else begin
                    nxt   = PRESSIONA;
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                dur_d = dur_q + 1'b1;
            end
            FIM: if (!habilitar) nxt = IDLE;
            default: nxt = IDLE;
        endcase

        // Stand-down beats game-over; both abandon whatever the state wanted to do.
        if (busy && (!habilitar || pronto)) begin
            nxt     = habilitar ? FIM : IDLE;
            dur_d   = '0;
            quiet_d = quiet_q;
            n_d     = n_q;
            idx_d   = idx_q;
            err_d   = err_q;
            we      = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st       <= IDLE;
            dur_q    <= '0;
            quiet_q  <= '0;
            n_q      <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
            leds_r   <= '0;
            leds_rr  <= '0;
            jogar_q  <= 1'b0;
            botoes_q <= '0;
        end else begin
            st       <= nxt;
            dur_q    <= dur_d;
            quiet_q  <= quiet_d;
            n_q      <= n_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
            leds_r   <= leds;
            leds_rr  <= leds_r;
            jogar_q  <= (nxt == INICIA);
            botoes_q <= (nxt == PRESSIONA) ? rd_data : 4'd0;
        end
    end

    assign jogar          = jogar_q;
    assign botoes         = botoes_q;
    assign ocupado        = busy;
    assign erro_sequencia = err_q;
    assign db_estado      = st;

endmodule

// File: tb/tb_jogador_automatico.sv
// Bench for jogador_automatico: a queue-based player model is compared against the DUT on every cycle.
// Directed scenarios pin the model with hand-computed literals.
// A randomized phase then exercises the DUT against the same model.
module tb_jogador_automatico;

    localparam int JOG   = 5;
    localparam int HOLD  = 10;
    localparam int GAP   = 10;
    localparam int QUIET = 100;
    localparam int MAXS  = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       habilitar = 1'b0;
    logic       pronto = 1'b0;
    logic [3:0] leds = 4'd0;
    logic       jogar, ocupado, erro_sequencia;
    logic [3:0] botoes, db_estado;

    always #5 clock = ~clock;

    jogador_automatico dut (
        .clock          (clock),
        .reset          (reset),
        .habilitar      (habilitar),
        .leds           (leds),
        .pronto         (pronto),
        .jogar          (jogar),
        .botoes         (botoes),
        .ocupado        (ocupado),
        .erro_sequencia (erro_sequencia),
        .db_estado      (db_estado)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    // Behavioural model. Mode numbers are the debug codes shown to the user.
    int m_mode = 0, m_left = 0, m_quiet = 0, m_pos = 0, m_err = 0, m_l1 = 0, m_l2 = 0;
    int m_seq[$];

    task automatic model_step(input logic hab, input logic pr, input logic [3:0] l);
        bit active;
        active = (m_mode >= 1 && m_mode <= 4);
        if (active && !hab) m_mode = 0;
        else if (active && pr) m_mode = 15;
        else begin
            case (m_mode)
                0: if (hab) begin m_mode = 1; m_err = 0; m_left = JOG; end
                1: begin
                    m_left--;
                    if (m_left == 0) begin m_mode = 2; m_seq.delete(); m_quiet = 0; end
                end
                2: begin
                    if (m_l1 != 0 && m_l2 == 0) begin
                        m_quiet = 0;
                        if (m_seq.size() == MAXS || $countones(m_l1) != 1) begin
                            m_err = 1; m_mode = 15;
                        end else m_seq.push_back(m_l1);
                    end else if (m_l1 != 0) m_quiet = 0;
                    else if (m_seq.size() > 0) begin
                        if (m_quiet == QUIET) begin m_mode = 3; m_pos = 0; m_left = HOLD; end
                        else m_quiet++;
                    end
                end
                3: begin
                    m_left--;
                    if (m_left == 0) begin m_mode = 4; m_left = GAP; end
                end
                4: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_pos++;
                        if (m_pos == m_seq.size()) begin m_mode = 2; m_seq.delete(); m_quiet = 0; end
                        else begin m_mode = 3; m_left = HOLD; end
                    end
                end
                default: if (!hab) m_mode = 0;
            endcase
        end
        m_l2 = m_l1;
        m_l1 = int'(l);
    endtask

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_mode = 0; m_left = 0; m_quiet = 0; m_pos = 0; m_err = 0; m_l1 = 0; m_l2 = 0;
            m_seq.delete();
        end else begin
            model_step(habilitar, pronto, leds);
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            logic       ej, eo, ee;
            logic [3:0] eb, ed;
            ej = (m_mode == 1);
            eo = (m_mode >= 1 && m_mode <= 4);
            ee = (m_err != 0);
            eb = (m_mode == 3 && m_pos < m_seq.size()) ? 4'(m_seq[m_pos]) : 4'd0;
            ed = 4'(m_mode);
            check("cycle_outputs", {21'd0, jogar, botoes, ocupado, erro_sequencia, db_estado},
                  {21'd0, ej, eb, eo, ee, ed});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic feed(input logic [3:0] p, input int on, input int off);
        leds = p;
        tick(on);
        leds = 4'd0;
        tick(off);
    endtask

    task automatic wait_estado(input logic [3:0] code, input int budget, input string nm);
        int k = 0;
        while (db_estado !== code && k < budget) begin @(negedge clock); k++; end
        if (db_estado !== code) fail_timeout(nm);
    endtask

    task automatic wait_press(input int budget, input string nm);
        int k = 0;
        while (botoes === 4'd0 && k < budget) begin @(negedge clock); k++; end
        if (botoes === 4'd0) fail_timeout(nm);
    endtask

    task automatic count_botoes(input logic [3:0] v, output int c);
        c = 0;
        while (botoes === v && c < 300) begin @(negedge clock); c++; end
    endtask

    task automatic count_estado(input logic [3:0] v, output int c);
        c = 0;
        while (db_estado === v && c < 300) begin @(negedge clock); c++; end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        logic [3:0] got;
        logic [3:0] exp_seq [3];
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0100; exp_seq[2] = 4'b1000;

        // Reset with habilitar held high
        habilitar = 1'b1;
        @(posedge clock);
        chk_en = 1'b1;
        tick(3);
        check("reset_jogar", jogar, 0);
        check("reset_botoes", botoes, 0);
        check("reset_ocupado", ocupado, 0);
        check("reset_erro", erro_sequencia, 0);
        check("reset_estado", db_estado, 0);
        reset = 1'b1;
        c = 0;
        while (!jogar && c < 10) begin @(negedge clock); c++; end
        count_estado(4'h1, c);
        check("jogar_width", c, JOG);
        check("ouve_after_jogar", db_estado, 2);

        // Single entry replay
        feed(4'b0001, 20, 0);
        wait_press(300, "single_press_wait");
        count_botoes(4'b0001, c);
        check("single_hold", c, 10);
        count_estado(4'h4, c);
        check("single_gap", c, 10);
        check("single_back_ouve", db_estado, 2);

        // Round of three
        feed(4'b0001, 3, 5);
        feed(4'b0100, 3, 5);
        feed(4'b1000, 3, 5);
        for (int k = 0; k < 3; k++) begin
            wait_press(300, "round3_press_wait");
            got = botoes;
            check("round3_value", got, exp_seq[k]);
            count_botoes(got, c);
            check("round3_hold", c, 10);
            count_estado(4'h4, c);
            check("round3_gap", c, 10);
        end
        check("round3_back_ouve", db_estado, 2);

        // Illegal pattern
        feed(4'b0011, 3, 0);
        wait_estado(4'hF, 20, "illegal_wait_fim");
        check("illegal_erro", erro_sequencia, 1);
        check("illegal_ocupado", ocupado, 0);
        habilitar = 1'b0;
        tick(1);
        check("illegal_idle", db_estado, 0);
        check("illegal_erro_sticky", erro_sequencia, 1);
        habilitar = 1'b1;
        tick(1);
        check("restart_inicia", db_estado, 1);
        check("restart_erro_clear", erro_sequencia, 0);

        // Overflow: sixteen entries fit, the seventeenth does not
        wait_estado(4'h2, 20, "overflow_wait_ouve");
        for (int i = 0; i < 16; i++) feed(4'(1 << (i % 4)), 2, 2);
        check("overflow_16_erro", erro_sequencia, 0);
        check("overflow_16_estado", db_estado, 2);
        feed(4'b0001, 2, 2);
        check("overflow_17_erro", erro_sequencia, 1);
        check("overflow_17_estado", db_estado, 15);
        habilitar = 1'b0;
        tick(1);
        check("overflow_idle", db_estado, 0);
        habilitar = 1'b1;

        // Game over in the middle of a press
        wait_estado(4'h2, 20, "pronto_wait_ouve");
        feed(4'b0010, 3, 3);
        feed(4'b0001, 3, 3);
        wait_press(300, "pronto_press_wait");
        tick(3);
        pronto = 1'b1;
        tick(1);
        pronto = 1'b0;
        check("pronto_botoes", botoes, 0);
        check("pronto_estado", db_estado, 15);
        check("pronto_ocupado", ocupado, 0);

        // Reset in the middle of the gap
        habilitar = 1'b0;
        tick(1);
        habilitar = 1'b1;
        wait_estado(4'h2, 20, "rst_wait_ouve");
        feed(4'b0100, 3, 3);
        wait_estado(4'h4, 300, "rst_wait_solta");
        tick(3);
        #2 reset = 1'b0;
        #1;
        check("async_rst_estado", db_estado, 0);
        check("async_rst_ocupado", ocupado, 0);
        check("async_rst_botoes", botoes, 0);
        tick(1);
        reset = 1'b1;

        // Randomized play
        for (int it = 0; it < 400; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                habilitar = 1'b0;
                tick($urandom_range(1, 3));
                habilitar = 1'b1;
            end else if (r < 5) begin
                pronto = 1'b1;
                tick(1);
                pronto = 1'b0;
                tick(2);
            end else if (r < 12) begin
                leds = 4'd0;
                tick($urandom_range(100, 140));
            end else begin
                logic [3:0] p;
                if ($urandom_range(0, 9) == 0) p = 4'($urandom_range(1, 15));
                else p = 4'(1 << $urandom_range(0, 3));
                feed(p, $urandom_range(1, 4), $urandom_range(1, 10));
            end
        end
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jogador_automatico.md
JOGADOR_AUTOMATICO -- requirements
Module: jogador_automatico

Interface
REQ-001 Parameter JOGAR_CYCLES, default 5, width in clock cycles of the jogar pulse sent to the game.
REQ-002 Parameter HOLD_CYCLES, default 10, cycles each replayed button pattern is held on botoes.
REQ-003 Parameter GAP_CYCLES, default 10, cycles botoes is held at 4'b0000 between replayed presses.
REQ-004 Parameter QUIET_CYCLES, default 100, consecutive cycles of leds==0 that mark the end of a LED display round.
REQ-005 Parameter MAX_SEQ, default 16, capacity of the internal sequence memory.
REQ-006 clock  input  1  single system clock, all state on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 habilitar  input  1  level; 1 = play the game autonomously, 0 = stand down.
REQ-009 leds  input  4  LED pattern driven by the game.
REQ-010 pronto  input  1  game-over indication from the game.
REQ-011 jogar  output  1  start request to the game.
REQ-012 botoes  output  4  button pattern driven into the game.
REQ-013 ocupado  output  1  high while a play session is active.
REQ-014 erro_sequencia  output  1  sticky flag: illegal LED pattern or memory overflow.
REQ-015 db_estado  output  4  current state code, for the 7-segment debug display.

Function
REQ-016 States and db_estado codes SHALL be: IDLE=0, INICIA=1, OUVE=2, PRESSIONA=3, SOLTA=4, FIM=4'hF.
REQ-017 IDLE: when habilitar=1, go to INICIA next cycle; otherwise stay in IDLE.
REQ-018 INICIA: jogar=1 for exactly JOGAR_CYCLES cycles; then go to OUVE with the entry count n=0 and the quiet counter at 0.
REQ-019 OUVE: leds is registered once; a transition of the registered value from 0 to nonzero SHALL store it at mem[n] and increment n.
REQ-020 OUVE: any nonzero registered leds clears the quiet counter; while leds==0 and n>0, the quiet counter increments.
REQ-021 OUVE: when the quiet counter reaches QUIET_CYCLES with n>0, go to PRESSIONA with idx=0; while n=0, stay in OUVE indefinitely.
REQ-022 OUVE: a stored pattern that is not one-hot, or a new entry arriving with n==MAX_SEQ, SHALL set erro_sequencia and go to FIM.
REQ-023 PRESSIONA: botoes=mem[idx] for HOLD_CYCLES cycles, then go to SOLTA.
REQ-024 SOLTA: botoes=0 for GAP_CYCLES cycles; then increment idx.
REQ-025 SOLTA exit: if idx==n, clear n and the quiet counter and go to OUVE; otherwise go to PRESSIONA.
REQ-026 leds SHALL be ignored in PRESSIONA and SOLTA, because the game echoes the presses on leds.
REQ-027 pronto=1 in INICIA, OUVE, PRESSIONA or SOLTA SHALL force FIM on the next cycle, with botoes=0 in that cycle.
REQ-028 habilitar=0 in any state other than IDLE SHALL force IDLE on the next cycle, with jogar=0 and botoes=0.
REQ-029 If pronto=1 and habilitar=0 in the same cycle, habilitar wins and the next state is IDLE.
REQ-030 FIM: hold botoes=0 and jogar=0; return to IDLE only when habilitar=0.
REQ-031 ocupado SHALL be 1 exactly in INICIA, OUVE, PRESSIONA and SOLTA.
REQ-032 erro_sequencia is cleared only by reset or by the IDLE-to-INICIA transition.
REQ-033 jogar and botoes SHALL be driven from registers (glitch-free); all counters are sized ceil(log2(max parameter + 1)) bits and saturate at their terminal counts, never wrapping.

Reset
REQ-034 With reset=0, the block SHALL asynchronously enter IDLE with jogar=0, botoes=0, ocupado=0, erro_sequencia=0, db_estado=0, n=0, idx=0 and all counters at 0.
REQ-035 Reset release SHALL take effect synchronously on the next rising clock edge.
REQ-036 Memory contents need no reset value; entries are never read at indices >= n.

Structure
REQ-037 State codes and default parameter values SHALL live in the shared package jogador_pkg.
REQ-038 The sequence storage SHALL be the sub-module memoria_jogadas: MAX_SEQ x 4, synchronous write, combinational read.
REQ-039 Control SHALL be one FSM, plus duration, quiet, n and idx counters, all in the top module.

Verification
REQ-040 Reset with habilitar=1 held -> outputs 0 during reset; after release, jogar=1 for 5 cycles, then db_estado=2.
REQ-041 In OUVE, drive leds 0001 for 20 cycles, then 0 for 100 cycles -> botoes=0001 for 10 cycles, then 0000 for 10 cycles, then db_estado=2.
REQ-042 Round of 3 (leds 0001, 0100, 1000 with gaps of 5 zero cycles) -> botoes replays 0001, 0100, 1000 in that order, 10 cycles on and 10 cycles off each.
REQ-043 leds=0011 during OUVE -> erro_sequencia=1 and db_estado=F; after habilitar=0, db_estado=0.
REQ-044 17 distinct LED entries in one round -> erro_sequencia=1 and FIM on the 17th entry.
REQ-045 pronto=1 mid-PRESSIONA -> botoes=0000 on the next cycle, db_estado=F and ocupado=0; reset asserted mid-SOLTA -> immediate return to IDLE.
